// File: rtl/chan_select_pkg.sv
// Shared constants, output-stage state type and width helper for the channel selector family.
package chan_select_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_e;

    // Index width that never collapses to zero bits for tiny channel counts.
    function automatic int clog2_min1(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: first set request at or after ptr, wrapping modulo N_CH.
module rr_pick
    import chan_select_pkg::*;
#(
    parameter int N_CH  = 32,
    parameter int SEL_W = clog2_min1(N_CH)
) (
    input  logic [N_CH-1:0]  req_i,
    input  logic [SEL_W-1:0] ptr_i,
    output logic [SEL_W-1:0] grant_o,
    output logic             found_o
);

    int   start_idx;
    int   idx;
    logic hit;

    // Scan N_CH positions starting at ptr; an out-of-range ptr restarts the scan at channel 0.
    always_comb begin
        grant_o   = '0;
        found_o   = 1'b0;
        idx       = 0;
        hit       = 1'b0;
        start_idx = (int'(ptr_i) < N_CH) ? int'(ptr_i) : 0;
        for (int k = 0; k < N_CH; k++) begin
            idx     = (start_idx + k >= N_CH) ? (start_idx + k - N_CH) : (start_idx + k);
            hit     = !found_o && req_i[idx[SEL_W-1:0]];
            grant_o = hit ? SEL_W'(idx) : grant_o;
            found_o = found_o | hit;
        end
    end

endmodule

// File: rtl/chan_select_rr.sv
// N-channel valid/ready selector with fixed or round-robin choice and one registered output stage.
// Optional out_par output when CHAN_SELECT_PARITY_EN is defined.
module chan_select_rr
    import chan_select_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int N_CH   = 32,
    parameter int SEL_W  = clog2_min1(N_CH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ena,
    input  logic                   mode,
    input  logic [SEL_W-1:0]       sel,
    input  logic [N_CH*DATA_W-1:0] in_data,
    input  logic [N_CH-1:0]        in_valid,
    output logic [N_CH-1:0]        in_ready,
    output logic [DATA_W-1:0]      out_data,
    output logic [SEL_W-1:0]       out_ch,
    output logic                   out_valid,
    input  logic                   out_ready
`ifdef CHAN_SELECT_PARITY_EN
    ,
    output logic                   out_par
`endif
);

    out_state_e        state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [SEL_W-1:0]  ch_q, ch_d;
    logic [SEL_W-1:0]  ptr_q, ptr_d;

    logic [SEL_W-1:0]  rr_grant;
    logic              rr_found;
    logic              fix_found;
    logic [SEL_W-1:0]  cand_idx;
    logic              cand_found;
    logic              load_ok;
    logic              load;
    logic [DATA_W-1:0] cand_data;

    rr_pick #(
        .N_CH  (N_CH),
        .SEL_W (SEL_W)
    ) u_rr_pick (
        .req_i   (in_valid),
        .ptr_i   (ptr_q),
        .grant_o (rr_grant),
        .found_o (rr_found)
    );

    // Fixed-mode candidate exists only when sel names a real channel that is valid.
    always_comb begin
        fix_found = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            fix_found = fix_found | ((sel == SEL_W'(i)) & in_valid[i]);
        end
    end

    // Candidate choice, load qualification and one-hot ready toward the winner.
    always_comb begin
        cand_idx   = (mode == MODE_RR) ? rr_grant : sel;
        cand_found = (mode == MODE_RR) ? rr_found : fix_found;
        load_ok    = !rst && !ena && ((state_q == ST_EMPTY) || out_ready);
        load       = load_ok && cand_found;
        for (int i = 0; i < N_CH; i++) begin
            in_ready[i] = load && (cand_idx == SEL_W'(i));
        end
    end

    // Data mux for the winning channel.
    always_comb begin
        cand_data = '0;
        for (int i = 0; i < N_CH; i++) begin
            cand_data = (cand_idx == SEL_W'(i)) ? in_data[i*DATA_W +: DATA_W] : cand_data;
        end
    end

    // Output-stage next state: a simultaneous drain and load keeps the stage full.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: state_d = load ? ST_FULL : ST_EMPTY;
            ST_FULL:  state_d = (load || !out_ready) ? ST_FULL : ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase

        if (load) begin
            data_d = cand_data;
            ch_d   = cand_idx;
        end else begin
            data_d = data_q;
            ch_d   = ch_q;
        end

        if (load && (mode == MODE_RR)) begin
            ptr_d = (cand_idx == SEL_W'(N_CH - 1)) ? '0 : (cand_idx + SEL_W'(1));
        end else begin
            ptr_d = ptr_q;
        end
    end

    // State, beat and pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            data_q  <= '0;
            ch_q    <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            ch_q    <= ch_d;
            ptr_q   <= ptr_d;
        end
    end

    assign out_data  = data_q;
    assign out_ch    = ch_q;
    assign out_valid = (state_q == ST_FULL);

`ifdef CHAN_SELECT_PARITY_EN
    logic par_q, par_d;

    function automatic logic calc_parity(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction

    // Parity follows the loaded beat and is held otherwise.
    always_comb begin
        if (load) begin
            par_d = calc_parity(cand_data);
        end else begin
            par_d = par_q;
        end
    end

    // Parity register.
    always_ff @(posedge clk) begin
        if (rst) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end

    assign out_par = par_q;
`endif

endmodule

// File: tb/tb_chan_select_rr.sv
// Self-checking bench for chan_select_rr: behavioural model plus directed literal checks, random phase.
module tb_chan_select_rr;

    localparam int N  = 32;
    localparam int DW = 32;
    localparam int SW = 5;
    localparam int N6 = 6;

    logic            clk = 1'b0;
    logic            rst, ena, mode, out_ready;
    logic [SW-1:0]   sel;
    logic [N*DW-1:0] in_data;
    logic [N-1:0]    in_valid, in_ready;
    logic [DW-1:0]   out_data;
    logic [SW-1:0]   out_ch;
    logic            out_valid;
    logic            out_par;

    logic             rst6, ena6, mode6, out_ready6;
    logic [2:0]       sel6;
    logic [N6*DW-1:0] in_data6;
    logic [N6-1:0]    in_valid6, in_ready6;
    logic [DW-1:0]    out_data6;
    logic [2:0]       out_ch6;
    logic             out_valid6;
    logic             out_par6;

    int tests = 0;
    int fails = 0;

    // Model state
    bit            m_valid;
    logic [DW-1:0] m_data;
    int            m_ch;
    int            m_ptr;

    always #5 clk = ~clk;

    chan_select_rr #(.DATA_W(DW), .N_CH(N)) u_dut (
        .clk(clk), .rst(rst), .ena(ena), .mode(mode), .sel(sel),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid),
        .out_ready(out_ready)
`ifdef CHAN_SELECT_PARITY_EN
        , .out_par(out_par)
`endif
    );

    chan_select_rr #(.DATA_W(DW), .N_CH(N6)) u_dut6 (
        .clk(clk), .rst(rst6), .ena(ena6), .mode(mode6), .sel(sel6),
        .in_data(in_data6), .in_valid(in_valid6), .in_ready(in_ready6),
        .out_data(out_data6), .out_ch(out_ch6), .out_valid(out_valid6),
        .out_ready(out_ready6)
`ifdef CHAN_SELECT_PARITY_EN
        , .out_par(out_par6)
`endif
    );

`ifndef CHAN_SELECT_PARITY_EN
    assign out_par  = 1'b0;
    assign out_par6 = 1'b0;
`endif

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Which channel the rules say is accepted this cycle, if any.
    function automatic void pick(output bit f, output int g);
        f = 1'b0;
        g = 0;
        if (rst || ena || (m_valid && !out_ready)) return;
        if (mode == 1'b0) begin
            if (int'(sel) < N && in_valid[sel]) begin
                f = 1'b1;
                g = int'(sel);
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                int c;
                c = (m_ptr + k) % N;
                if (!f && in_valid[c]) begin
                    f = 1'b1;
                    g = c;
                end
            end
        end
    endfunction

    // Model update at the active edge.
    always @(posedge clk) begin
        bit f;
        int g;
        pick(f, g);
        if (rst) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_ch    <= 0;
            m_ptr   <= 0;
        end else if (f) begin
            m_valid <= 1'b1;
            m_data  <= in_data[g*DW +: DW];
            m_ch    <= g;
            if (mode) m_ptr <= (g == N - 1) ? 0 : g + 1;
        end else if (out_ready) begin
            m_valid <= 1'b0;
        end
    end

    // Compare process on the opposite edge.
    always @(negedge clk) begin
        bit           f;
        int           g;
        logic [N-1:0] e;
        pick(f, g);
        e = '0;
        if (f) e[g] = 1'b1;
        chk("m_in_ready", 64'(in_ready), 64'(e));
        chk("m_out_valid", 64'(out_valid), 64'(m_valid));
        chk("m_out_data", 64'(out_data), 64'(m_data));
        chk("m_out_ch", 64'(out_ch), 64'(m_ch));
`ifdef CHAN_SELECT_PARITY_EN
        chk("m_out_par", 64'(out_par), 64'(^m_data));
`endif
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int seq [5];
        seq = '{0, 3, 31, 0, 3};

        rst = 1'b1; ena = 1'b0; mode = 1'b1; sel = '0; out_ready = 1'b1;
        in_valid = '1;
        for (int i = 0; i < N; i++) in_data[i*DW +: DW] = 32'hA5A5_0000 | 32'(i);
        rst6 = 1'b1; ena6 = 1'b0; mode6 = 1'b0; sel6 = 3'd7; out_ready6 = 1'b1;
        in_valid6 = '1;
        for (int i = 0; i < N6; i++) in_data6[i*DW +: DW] = 32'h0000_0007;

        tick(); tick();
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_ch", 64'(out_ch), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);

        tick();
        rst = 1'b0; rst6 = 1'b0;
        @(negedge clk);
        chk("rr_first_ready", 64'(in_ready), 64'h1);

        tick();
        mode = 1'b0; sel = 5'd5; in_valid = 32'h20;
        @(negedge clk);
        chk("rr_first_ch", 64'(out_ch), 64'd0);
        chk("fix_ready", 64'(in_ready), 64'h20);

        tick();
        @(negedge clk);
        chk("fix_data", 64'(out_data), 64'hA5A5_0005);
        chk("fix_ch", 64'(out_ch), 64'd5);
        tick();
        @(negedge clk);
        chk("fix_steady_valid", 64'(out_valid), 64'd1);
        chk("fix_steady_ready", 64'(in_ready), 64'h20);

        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; mode = 1'b1; in_valid = 32'h8000_0009;
        @(negedge clk);
        chk("rr_ready0", 64'(in_ready), 64'h1);
        for (int k = 0; k < 5; k++) begin
            tick();
            if (k == 4) out_ready = 1'b0;
            @(negedge clk);
            chk($sformatf("rr_seq%0d", k), 64'(out_ch), 64'(seq[k]));
        end

        for (int k = 0; k < 4; k++) begin
            tick();
            @(negedge clk);
            chk("bp_ch", 64'(out_ch), 64'd3);
            chk("bp_data", 64'(out_data), 64'hA5A5_0003);
            chk("bp_ready", 64'(in_ready), 64'd0);
        end
        tick();
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", 64'(in_ready), 64'h8000_0000);

        tick();
        ena = 1'b1;
        @(negedge clk);
        chk("ena_ch31", 64'(out_ch), 64'd31);
        chk("ena_ready", 64'(in_ready), 64'd0);
        tick();
        @(negedge clk);
        chk("ena_drain", 64'(out_valid), 64'd0);
        tick();
        ena = 1'b0;
        @(negedge clk);
        chk("ena_resume_ready", 64'(in_ready), 64'h1);
        tick();
        @(negedge clk);
        chk("ena_resume_ch", 64'(out_ch), 64'd0);

        for (int c = 0; c < 3000; c++) begin
            tick();
            rst       = ($urandom_range(0, 63) == 0);
            ena       = ($urandom_range(0, 7) == 0);
            mode      = ($urandom_range(0, 3) != 0);
            sel       = SW'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = (c % 3 == 0) ? ($urandom & $urandom & $urandom) : $urandom;
            for (int i = 0; i < N; i++) in_data[i*DW +: DW] = $urandom;
        end

        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("n6_sel7_ready", 64'(in_ready6), 64'd0);
        chk("n6_sel7_valid", 64'(out_valid6), 64'd0);
        tick();
        sel6 = 3'd2;
        @(negedge clk);
        chk("n6_sel2_ready", 64'(in_ready6), 64'h04);
        tick();
        @(negedge clk);
        chk("n6_valid", 64'(out_valid6), 64'd1);
        chk("n6_ch", 64'(out_ch6), 64'd2);
        chk("n6_data", 64'(out_data6), 64'h7);
`ifdef CHAN_SELECT_PARITY_EN
        chk("n6_par", 64'(out_par6), 64'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
